// File: rtl/uart_pkg.sv
// Shared constants and launch-FSM encoding for the nibble assembler and its FIFO.
package uart_pkg;

  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_ACK_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } launch_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte ring buffer. A push while full is accepted only when a pop happens
// in the same cycle; the freed head slot receives the new byte.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head reads as zero when nothing is stored so stale RAM never leaks out.
  assign head = empty ? 8'h00 : mem[rd_ptr];

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nibble_assembler.sv
// Pairs decoded nibbles into bytes, queues them, and hands the queue head
// to a UART transmitter through a start/busy handshake with retry.
module nibble_assembler
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             nibble_in,
  input  logic                   nibble_valid,
  input  logic                   tx_busy,
  output logic [7:0]             byte_out,
  output logic                   tx_start,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic          half;
  logic [3:0]    low_nib;
  logic          byte_done;
  logic [7:0]    byte_asm;
  logic          pop;
  logic          fifo_empty;
  launch_state_t state, state_nxt;
  logic [TW-1:0] ack_cnt, ack_cnt_nxt;

  // The second nibble of a pair completes the byte in its own strobe cycle.
  assign byte_done = nibble_valid && half;
  assign byte_asm  = {nibble_in, low_nib};

  // Half flag toggles per strobe; the low nibble waits here for its partner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half    <= 1'b0;
      low_nib <= '0;
    end else if (nibble_valid) begin
      half <= !half;
      if (!half) low_nib <= nibble_in;
    end
  end

  // Sticky overflow: a finished byte found the queue full with no pop to make room.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          overflow <= 1'b0;
    else if (byte_done && full && !pop)  overflow <= 1'b1;
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (byte_done),
    .push_data (byte_asm),
    .pop       (pop),
    .head      (byte_out),
    .count     (count),
    .full      (full),
    .empty     (fifo_empty)
  );

  // Launch FSM state and ack-timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ack_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ack_cnt <= ack_cnt_nxt;
    end
  end

  // Launch sequencing: the head stays queued until the transmitter finishes,
  // so a missed acknowledge simply relaunches the same byte.
  always_comb begin
    state_nxt   = state;
    ack_cnt_nxt = ack_cnt;
    tx_start    = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !tx_busy) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        tx_start    = 1'b1;
        ack_cnt_nxt = '0;
        state_nxt   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy)                              state_nxt   = WAIT_DONE;
        else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) state_nxt   = IDLE;
        else                                      ack_cnt_nxt = ack_cnt + TW'(1);
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nibble_assembler.sv
// Self-checking bench for nibble_assembler: directed sequences, a vector
// table for the fill/overflow case, and random traffic against a queue model.
module tb_nibble_assembler;

  localparam int DEPTH  = 4;
  localparam int ACK_TO = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    nibble_in = '0;
  logic          nibble_valid = 1'b0;
  logic          tx_busy = 1'b1;
  logic [7:0]    byte_out;
  logic          tx_start;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Transmitter behaviour: 0/1 = tx_busy forced, 2 = busy follows tx_start.
  int busy_mode = 1;
  int busy_len  = 0;   // 0 selects a random busy length per transfer
  int busy_left = 0;
  bit pend      = 0;
  bit mdl_busy  = 0;
  logic [7:0] sent_q[$];

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] exp_sent[$];
  bit         m_half, m_ovf, m_prev_busy, m_pop, m_done;
  logic [3:0] m_low;
  logic [7:0] m_nb;

  typedef struct {
    logic          nv;
    logic [3:0]    nib;
    logic [CW-1:0] cnt;
    logic          fl;
    logic          ovf;
    logic [7:0]    bo;
  } vec_t;
  vec_t vecs[10];

  nibble_assembler #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .nibble_in    (nibble_in),
    .nibble_valid (nibble_valid),
    .tx_busy      (tx_busy),
    .byte_out     (byte_out),
    .tx_start     (tx_start),
    .count        (count),
    .full         (full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in, updated on the falling edge; logs every launched byte.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      pend = 0; busy_left = 0; mdl_busy = 0;
      sent_q.delete();
    end else begin
      if (tx_start) sent_q.push_back(byte_out);
      if (busy_mode != 2) begin
        pend = 0; busy_left = 0; mdl_busy = 0;
      end else begin
        if (pend) begin
          mdl_busy  = 1;
          busy_left = (busy_len > 0) ? busy_len : int'($urandom_range(1, 6));
          pend      = 0;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) mdl_busy = 0;
        end
        if (tx_start) pend = 1;
      end
    end
    tx_busy = (busy_mode == 2) ? mdl_busy : busy_mode[0];
  end

  // Reference model: byte queue; a transfer completes when busy falls.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete(); exp_sent.delete();
      m_half = 0; m_ovf = 0; m_prev_busy = 0; m_low = '0;
    end else begin
      m_pop  = m_prev_busy && !tx_busy && (m_q.size() > 0);
      m_done = nibble_valid && m_half;
      m_nb   = {nibble_in, m_low};
      if (nibble_valid) begin
        if (!m_half) m_low = nibble_in;
        m_half = !m_half;
      end
      if (m_pop) exp_sent.push_back(m_q.pop_front());
      if (m_done) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_nb);
        else                    m_ovf = 1;
      end
      m_prev_busy = tx_busy;
    end
  end

  function automatic logic [7:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : 8'h00;
  endfunction

  function automatic logic [7:0] sent_at(input int i);
    return (i < sent_q.size()) ? sent_q[i] : 8'hxx;
  endfunction

  function automatic vec_t mk(input logic nv, input logic [3:0] nib, input logic [CW-1:0] cnt,
                              input logic fl, input logic ovf, input logic [7:0] bo);
    vec_t v;
    v.nv = nv; v.nib = nib; v.cnt = cnt; v.fl = fl; v.ovf = ovf; v.bo = bo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [3:0] n);
    nibble_in    = n;
    nibble_valid = 1'b1;
    step();
    nibble_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (count != 0 && t < 300) begin
      step();
      t++;
    end
    chk(name, 32'(t < 300), 1);
  endtask

  task automatic chk_sent(input string name, input logic [7:0] exp[$]);
    chk({name, " count"}, sent_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) chk({name, " byte"}, sent_at(i), exp[i]);
  endtask

  initial begin
    int t, starts, dens;
    int tcyc[$];

    // ---- reset state (asserted asynchronously, checked before any clock) ----
    #1 reset = 1'b0;
    #1;
    chk("reset count",    count,    0);
    chk("reset byte_out", byte_out, 8'h00);
    chk("reset tx_start", tx_start, 0);
    chk("reset full",     full,     0);
    chk("reset overflow", overflow, 0);
    step(); step();
    reset = 1'b1;

    // ---- 5 then A makes A5, one launch, drains after busy falls ----
    do_reset(); busy_mode = 2; busy_len = 10; step();
    strobe(4'h5); strobe(4'hA);
    chk("A5 byte_out", byte_out, 8'hA5);
    chk("A5 count",    count,    1);
    starts = 0; t = 0;
    while (count != 0 && t < 60) begin
      if (tx_start) begin
        starts++;
        chk("A5 launch byte", byte_out, 8'hA5);
      end
      step(); t++;
    end
    chk("A5 drained in time", 32'(t < 60), 1);
    chk("A5 single tx_start", starts, 1);
    chk("A5 no overflow", overflow, 0);
    busy_len = 0;

    // ---- three bytes go out in order ----
    do_reset(); busy_mode = 2; step();
    strobe(4'h0); strobe(4'h1); strobe(4'h2); strobe(4'h3); strobe(4'h4); strobe(4'h5);
    drain("order drain");
    chk_sent("order sent", '{8'h10, 8'h32, 8'h54});

    // ---- busy held: fill to DEPTH, fifth byte dropped (vector table) ----
    vecs[0] = mk(1, 4'h1, 0, 0, 0, 8'h00);
    vecs[1] = mk(1, 4'h2, 1, 0, 0, 8'h21);
    vecs[2] = mk(1, 4'h3, 1, 0, 0, 8'h21);
    vecs[3] = mk(1, 4'h4, 2, 0, 0, 8'h21);
    vecs[4] = mk(1, 4'h5, 2, 0, 0, 8'h21);
    vecs[5] = mk(1, 4'h6, 3, 0, 0, 8'h21);
    vecs[6] = mk(1, 4'h7, 3, 0, 0, 8'h21);
    vecs[7] = mk(1, 4'h8, 4, 1, 0, 8'h21);
    vecs[8] = mk(1, 4'h9, 4, 1, 0, 8'h21);
    vecs[9] = mk(1, 4'hA, 4, 1, 1, 8'h21);
    do_reset(); busy_mode = 1; step();
    for (int i = 0; i < 10; i++) begin
      nibble_in    = vecs[i].nib;
      nibble_valid = vecs[i].nv;
      step();
      chk($sformatf("fill[%0d] count", i),    count,    vecs[i].cnt);
      chk($sformatf("fill[%0d] full", i),     full,     vecs[i].fl);
      chk($sformatf("fill[%0d] overflow", i), overflow, vecs[i].ovf);
      chk($sformatf("fill[%0d] byte_out", i), byte_out, vecs[i].bo);
      chk($sformatf("fill[%0d] tx_start", i), tx_start, 0);
    end
    nibble_valid = 1'b0;
    sent_q.delete(); busy_mode = 2;
    drain("fill drain");
    chk_sent("fill sent", '{8'h21, 8'h43, 8'h65, 8'h87});
    chk("fill overflow sticky", overflow, 1);

    // ---- reset with a queued byte and a half nibble pending ----
    busy_mode = 1; step();
    strobe(4'h6); strobe(4'h7); strobe(4'h3);
    chk("pre-reset count", count, 1);
    reset = 1'b0;
    #1;
    chk("mid reset count",    count,    0);
    chk("mid reset byte_out", byte_out, 8'h00);
    chk("mid reset overflow", overflow, 0);
    chk("mid reset full",     full,     0);
    chk("mid reset tx_start", tx_start, 0);
    step();
    reset = 1'b1;
    strobe(4'h1); strobe(4'h2);
    chk("post reset byte_out", byte_out, 8'h21);
    chk("post reset count",    count,    1);

    // ---- no acknowledge: relaunch every ACK_TIMEOUT+2 cycles ----
    do_reset(); busy_mode = 0; step();
    strobe(4'h7); strobe(4'hC);
    tcyc.delete();
    for (int c = 0; c < 4 * (ACK_TO + 2) + 2; c++) begin
      if (tx_start) begin
        tcyc.push_back(c);
        chk("retry byte_out", byte_out, 8'hC7);
      end
      step();
    end
    chk("retry launches", 32'(tcyc.size() >= 3), 1);
    for (int i = 1; i < tcyc.size(); i++) chk("retry period", tcyc[i] - tcyc[i-1], ACK_TO + 2);
    chk("retry count kept", count, 1);

    // ---- full queue: byte completes in the pop cycle ----
    do_reset(); busy_mode = 0; step();
    strobe(4'h1); strobe(4'h2);
    t = 0;
    while (!tx_start && t < 10) begin step(); t++; end
    chk("simul launch seen", tx_start, 1);
    busy_mode = 1;
    strobe(4'h3); strobe(4'h4); strobe(4'h5); strobe(4'h6); strobe(4'h7); strobe(4'h8);
    chk("simul pre count", count, 4);
    chk("simul pre full",  full,  1);
    strobe(4'h9);
    nibble_in = 4'hA; nibble_valid = 1'b1; busy_mode = 0;
    step();
    nibble_valid = 1'b0; busy_mode = 1;
    chk("simul count",    count,    4);
    chk("simul full",     full,     1);
    chk("simul overflow", overflow, 0);
    chk("simul byte_out", byte_out, 8'h43);
    sent_q.delete(); busy_mode = 2;
    drain("simul drain");
    chk_sent("simul sent", '{8'h43, 8'h65, 8'h87, 8'hA9});
    chk("simul overflow end", overflow, 0);

    // ---- random traffic against the queue model ----
    do_reset(); busy_mode = 2; step();
    for (int blk = 0; blk < 4; blk++) begin
      dens = $urandom_range(1, 4);
      for (int c = 0; c < 100; c++) begin
        nibble_valid = ($urandom_range(0, 3) < dens);
        nibble_in    = 4'($urandom_range(0, 15));
        step();
        chk("rand count",    count,    m_q.size());
        chk("rand byte_out", byte_out, m_head());
        chk("rand full",     full,     32'(m_q.size() == DEPTH));
        chk("rand overflow", overflow, m_ovf);
      end
    end
    nibble_valid = 1'b0;
    drain("rand drain");
    chk_sent("rand sent", exp_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/nibble_assembler.md
NIBBLE_ASSEMBLER -- requirements
Module: nibble_assembler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, byte-FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4, cycles to wait for tx_busy after tx_start.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port nibble_in  input  4  decoded data nibble from the Hamming decoder.
REQ-006 SHALL have port nibble_valid  input  1  one-cycle strobe qualifying nibble_in.
REQ-007 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-008 SHALL have port byte_out  output  8  byte presented to the transmitter (FIFO head).
REQ-009 SHALL have port tx_start  output  1  one-cycle transmitter enable pulse.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  bytes held, including the one in flight.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky: a completed byte was dropped.

Function
REQ-013 SHALL pair nibbles: the first strobed nibble goes to byte[3:0], the second to byte[7:4].
REQ-014 SHALL use a half flag: it toggles on each nibble_valid; the second nibble completes a byte.
REQ-015 SHALL push a completed byte in the cycle after the second strobe when not full; latency nibble_valid to count increment is 1 cycle.
REQ-016 SHALL drop a completed byte when full (no pop that cycle), set overflow, and clear the half flag.
REQ-017 SHALL accept the push when a pop and a push occur in the same cycle while full; count stays DEPTH; overflow is not set.
REQ-018 SHALL wrap read/write pointers modulo DEPTH.
REQ-019 SHALL implement launch FSM states IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
REQ-020 IDLE -> LAUNCH SHALL occur when count > 0 and tx_busy == 0.
REQ-021 LAUNCH SHALL assert tx_start for exactly one cycle, then go to WAIT_ACK.
REQ-022 WAIT_ACK -> WAIT_DONE SHALL occur on tx_busy == 1; after ACK_TIMEOUT cycles without it, SHALL go to IDLE with no pop, so a retry follows.
REQ-023 WAIT_DONE -> IDLE SHALL occur on tx_busy == 0 and SHALL pop the head in that cycle.
REQ-024 SHALL hold byte_out stable at the FIFO head from LAUNCH until the pop.
REQ-025 SHALL drive byte_out to 8'h00 when count == 0.
REQ-026 SHALL accept nibble strobes in every FSM state; input never stalls.

Reset
REQ-027 On reset low, the block SHALL immediately set FSM=IDLE, pointers=0, count=0, half=0, overflow=0, tx_start=0, byte_out=8'h00, full=0.
REQ-028 Reset mid-transmission SHALL discard all bytes and any pending half nibble; the first nibble after release SHALL be treated as a low nibble.

Structure
REQ-029 The FSM state enum and the default DEPTH/ACK_TIMEOUT constants SHALL live in shared package uart_pkg.
REQ-030 Byte storage SHALL be sub-module byte_fifo (push/pop/head/count); nibble pairing and the FSM SHALL stay in nibble_assembler.

Verification
REQ-031 The bench SHALL drive nibbles 4'h5 then 4'hA, with tx_busy following tx_start by 1 cycle for 10 cycles; required: byte_out=8'hA5, one tx_start, and count returns to 0 after busy falls.
REQ-032 The bench SHALL hold tx_busy=1 and drive 10 nibbles with DEPTH=4; required: count=4, full=1, overflow=1, and the fifth byte dropped.
REQ-033 The bench SHALL keep tx_busy at 0 after tx_start; required: tx_start repeats every ACK_TIMEOUT+2 cycles with byte_out unchanged.
REQ-034 When full, the bench SHALL complete a byte in the same cycle as WAIT_DONE->IDLE; required: count stays 4 and overflow stays 0.
REQ-035 The bench SHALL drive one nibble 4'h3, assert reset low for 1 cycle, then drive 4'h1 and 4'h2; required: byte_out=8'h21.
REQ-036 The bench SHALL queue three bytes 8'h10, 8'h32, 8'h54 (nibble pairs 0/1, 2/3, 4/5); required: they are transmitted in order with exactly one tx_start each.
